// File: rtl/fp_mul_param.sv
// Parametrised floating-point multiplier (sign / EXP_W exponent / MAN_W fraction).
// An iterative radix-2 shift-add significand multiplier runs under a four-state
// FSM: IDLE -> MULT -> NORM -> ROUND. Rounding is round-to-nearest-even.
// Denormal inputs are flushed to zero. Results that would be denormal are also
// flushed to zero. Every operation takes the same number of cycles.
module fp_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow_flag,
    output logic         underflow_flag,
    output logic         invalid_flag
);

    localparam int N  = MAN_W + 1;       // significand width including hidden one
    localparam int PW = 2 * N;           // full product width
    localparam int EW = EXP_W + 2;       // signed exponent working width
    localparam int CW = $clog2(N + 1);
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, MULT, NORM, ROUND} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          mcand;
    logic [N-1:0]           mplier;
    logic [PW-1:0]          prod;
    logic signed [EW-1:0]   exp_r;
    logic                   sign_r;
    logic                   inv_r;
    logic                   inf_r;
    logic                   zero_r;
    logic [MAN_W-1:0]       frac_r;
    logic                   guard_r;
    logic                   sticky_r;

    // Operand unpack and classification (only meaningful in IDLE)
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic signed [EW-1:0] exp_sum;

    assign ea     = A[W-2 -: EXP_W];
    assign eb     = B[W-2 -: EXP_W];
    assign fa     = A[MAN_W-1:0];
    assign fb     = B[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(BIAS);

    // Product normalised so the leading one sits just above pn's top bit
    logic [PW-2:0] pn;
    assign pn = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

    // Round-to-nearest-even; a carry out of the fraction means the significand
    // became exactly 2.0, so the fraction is already zero and only the exponent moves
    logic                 rnd;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] exp_f;
    logic                 ovf, unf;

    assign rnd      = guard_r & (sticky_r | frac_r[0]);
    assign frac_sum = {1'b0, frac_r} + {{MAN_W{1'b0}}, rnd};
    assign exp_f    = exp_r + $signed({{(EW-1){1'b0}}, frac_sum[MAN_W]});
    assign ovf      = (exp_f >= $signed(EMAX));
    assign unf      = exp_f[EW-1] || (exp_f == '0);

    assign busy = (state != IDLE);

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            prod           <= '0;
            exp_r          <= '0;
            sign_r         <= 1'b0;
            inv_r          <= 1'b0;
            inf_r          <= 1'b0;
            zero_r         <= 1'b0;
            frac_r         <= '0;
            guard_r        <= 1'b0;
            sticky_r       <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
            invalid_flag   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, 1'b1, fa};
                        mplier <= {1'b1, fb};
                        prod   <= '0;
                        cnt    <= CW'(N);
                        exp_r  <= exp_sum;
                        sign_r <= A[W-1] ^ B[W-1];
                        inv_r  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
                        inf_r  <= a_inf | b_inf;
                        zero_r <= a_zero | b_zero;
                        state  <= MULT;
                    end
                end
                MULT: begin
                    if (cnt == '0) begin
                        state <= NORM;
                    end else begin
                        prod   <= prod + (mplier[0] ? mcand : '0);
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end
                end
                NORM: begin
                    frac_r   <= pn[PW-2 -: MAN_W];
                    guard_r  <= pn[N-1];
                    sticky_r <= |pn[N-2:0];
                    exp_r    <= exp_r + $signed({{(EW-1){1'b0}}, prod[PW-1]});
                    state    <= ROUND;
                end
                ROUND: begin
                    overflow_flag  <= 1'b0;
                    underflow_flag <= 1'b0;
                    invalid_flag   <= 1'b0;
                    if (inv_r) begin
                        result       <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        invalid_flag <= 1'b1;
                    end else if (inf_r) begin
                        result <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (zero_r) begin
                        result <= {sign_r, {(W-1){1'b0}}};
                    end else if (ovf) begin
                        result        <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        overflow_flag <= 1'b1;
                    end else if (unf) begin
                        result         <= {sign_r, {(W-1){1'b0}}};
                        underflow_flag <= 1'b1;
                    end else begin
                        result <= {sign_r, exp_f[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_param.sv
// Bench for fp_mul_param: a default single-precision instance and a half-precision
// instance, directed operands, expected results queued at issue time and
// checked when done fires.
module tb_fp_mul_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start16;
    logic [31:0] a32, b32, res32;
    logic [15:0] a16, b16, res16;
    logic        busy32, done32, ovf32, unf32, inv32;
    logic        busy16, done16, ovf16, unf16, inv16;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, invalid}
        int          done_cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    fp_mul_param dut32 (
        .clk(clk), .reset(reset), .start(start32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .result(res32),
        .overflow_flag(ovf32), .underflow_flag(unf32), .invalid_flag(inv32)
    );

    fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .result(res16),
        .overflow_flag(ovf16), .underflow_flag(unf16), .invalid_flag(inv16)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop and compare whenever a done pulse is seen
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) chk("spurious_done32", done32, 0);
            else begin
                e = q32.pop_front();
                chk({e.tag, "_res"}, res32, e.res);
                chk({e.tag, "_flags"}, {ovf32, unf32, inv32}, e.flg);
                chk({e.tag, "_latency"}, cyc, e.done_cyc);
            end
        end
        if (done16) begin
            if (q16.size() == 0) chk("spurious_done16", done16, 0);
            else begin
                e = q16.pop_front();
                chk({e.tag, "_res"}, res16, e.res);
                chk({e.tag, "_flags"}, {ovf16, unf16, inv16}, e.flg);
                chk({e.tag, "_latency"}, cyc, e.done_cyc);
            end
        end
    end

    // Drive one start pulse; returns just after the accepting edge
    task automatic issue(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [2:0] ef, input string tag);
        exp_t e;
        e.tag = tag;
        e.res = er;
        e.flg = ef;
        e.done_cyc = cyc + 1 + (h ? 14 : 27);
        if (h) begin
            a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; q16.push_back(e);
        end else begin
            a32 = a; b32 = b; start32 = 1'b1; q32.push_back(e);
        end
        @(posedge clk); #1;
        start16 = 1'b0;
        start32 = 1'b0;
    endtask

    // Wait (bounded) for done, checking busy stays high meanwhile;
    // returns at the negedge of the done cycle
    task automatic wait_done(input bit h);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (h ? done16 : done32) seen = 1'b1;
            else chk(h ? "busy16" : "busy32", h ? busy16 : busy32, 1);
        end
        chk(h ? "timeout16" : "timeout32", seen, 1);
    endtask

    task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] ef, input string tag);
        issue(h, a, b, er, ef, tag);
        wait_done(h);
    endtask

    initial begin
        reset = 1'b1;
        start32 = 1'b0; start16 = 1'b0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_out32", {res32, ovf32, unf32, inv32}, 0);
        chk("rst_out16", {busy16, done16, res16, ovf16, unf16, inv16}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Main function and special values, single precision
        op(0, 32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, "mul_3x2.5");
        op(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, "overflow");
        op(0, 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, "underflow");
        op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, "inf_x_zero");
        op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, "neg_inf");
        op(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, "rne_tie");
        op(0, 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000, "round_carry");
        op(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, "round_down");
        op(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, "nan_in");
        op(0, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, "neg_zero");
        op(0, 32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, "denorm_flush");

        // start while busy is ignored
        issue(0, 32'h3F800000, 32'h40400000, 32'h40400000, 3'b000, "ignore_mid");
        repeat (5) @(posedge clk);
        #1;
        a32 = 32'h7F800000; b32 = 32'h00000000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        wait_done(0);

        // back-to-back: second start lands in the done cycle of the first
        issue(0, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000, "b2b_first");
        wait_done(0);
        issue(0, 32'hC0400000, 32'h40400000, 32'hC1100000, 3'b000, "b2b_second");
        wait_done(0);

        // reset mid-operation aborts with no done
        issue(0, 32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, "aborted");
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        chk("abort_out", {res32, ovf32, unf32, inv32}, 0);
        reset = 1'b0;
        q32.delete();
        repeat (40) @(posedge clk);
        #1;

        // Half precision instance
        op(1, 32'h3C00, 32'hC000, 32'hC000, 3'b000, "h_1x-2");
        op(1, 32'h7800, 32'h7800, 32'h7C00, 3'b100, "h_overflow");
        op(1, 32'h3E00, 32'h4000, 32'h4200, 3'b000, "h_1.5x2");

        repeat (3) @(posedge clk);
        #1;
        chk("q32_drained", q32.size(), 0);
        chk("q16_drained", q16.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_mul_param.md
Name: fp_mul_param

Overview:
- Parametrised successor to the single-precision FP multiplier top.
- Multiplies two IEEE-754-style operands of configurable exponent and mantissa width.
- Uses an iterative radix-2 shift-add significand multiplier under one internal FSM.
- Adds round-to-nearest-even, special-value handling, underflow/invalid flags and a busy/done handshake that allows back-to-back operation.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
A  input  W  operand A, sampled on accepted start
B  input  W  operand B, sampled on accepted start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result and flags valid
result  output  W  product; held until next done
overflow_flag  output  1  finite result exceeded range, forced to inf
underflow_flag  output  1  nonzero result below min normal, flushed to zero
invalid_flag  output  1  NaN operand or inf*0

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on port reset.
- Reset:
  - FSM goes to IDLE.
  - busy, done, result and all flags are 0.
  - Reset mid-operation aborts it; no done pulse follows.
- FSM states:
  - IDLE: start=1 latches A/B, unpacks fields, classifies operands, sets the counter to MAN_W+1 and moves to MULT.
  - MULT: one shift-add step per cycle. Leaves for NORM when the counter reaches 0.
  - NORM: normalises the product and the exponent.
  - ROUND: applies rounding and special-case overrides, writes result and flags, pulses done and returns to IDLE.
- busy = (state != IDLE).
- Latency:
  - done is asserted exactly MAN_W+4 clock edges after the edge that accepted start (27 for the defaults).
  - Latency is fixed, including special cases.
- Handshake:
  - start while busy=1 is ignored, with no effect on the operation in flight.
  - done is high in the cycle the FSM is back in IDLE, so a start in that same cycle is accepted (back-to-back).
  - result and flags hold until overwritten by the next done.
- Arithmetic:
  - bias = 2^(EXP_W-1)-1.
  - Significand = {1, frac}, MAN_W+1 bits; product is 2*(MAN_W+1) bits.
  - Exponent is computed as eA+eB-bias in EXP_W+2-bit signed arithmetic.
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - Guard bit = first dropped bit; sticky = OR of the remaining dropped bits.
  - RNE: round up if guard & (sticky | lsb). A mantissa carry-out renormalises and increments the exponent again.
  - Sign = sA ^ sB for all non-NaN results.
- Operand classes:
  - exp=0 means zero; denormals are flushed to zero on input.
  - exp all-ones with frac=0 means inf.
  - exp all-ones with frac!=0 means NaN.
- Result priority:
  1. Any NaN operand, or inf*zero → canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0); invalid=1.
  2. inf * nonzero → signed inf; no flags.
  3. zero * finite → signed zero; no flags.
  4. Final exponent >= 2^EXP_W-1 → signed inf; overflow=1.
  5. Final exponent <= 0 → signed zero; underflow=1.
  6. Otherwise the normal packed result.
- At most one flag is set per operation; all flags clear on every done.

Test Plan:
1. Defaults: A=0x40400000 (3.0), B=0x40200000 (2.5) → result=0x40F00000, no flags, done exactly 27 edges after start, busy high throughout.
2. A=0x7F000000, B=0x7F000000 → 0x7F800000, overflow=1. Also A=0x00800000, B=0x3F000000 → 0x00000000, underflow=1.
3. A=0x7F800000, B=0x00000000 → 0x7FC00000, invalid=1. Also A=0xFF800000, B=0x40000000 → 0xFF800000, no flags.
4. RNE tie: A=0x3F800001, B=0x3FC00000 → 0x3FC00002.
5. Back-to-back and busy:
   - Start pulsed mid-op → ignored.
   - Start in the done cycle → second op accepted, its done 27 edges later.
   - reset asserted at cycle 10 → all outputs 0, no done.
6. EXP_W=5, MAN_W=10: A=0x3C00 (1.0), B=0xC000 (-2.0) → 0xC000, done 14 edges after start. Also A=0x7800, B=0x7800 → 0x7C00, overflow=1.
